// File: rtl/instr_sequencer_pkg.sv
// Shared constants and types for the 4-bit CPU control sequencer:
// instruction field widths, opcode values, FSM state codes and the
// decoded instruction-class bundle.
package cpu_ctrl_pkg;

  localparam int INSTR_W = 8;
  localparam int OPC_W   = 4;
  localparam int REG_W   = 2;
  localparam int ALU_W   = 3;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LD   = 4'h8;
  localparam logic [OPC_W-1:0] OP_ST   = 4'h9;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'hA;
  localparam logic [OPC_W-1:0] OP_BRZ  = 4'hB;
  localparam logic [OPC_W-1:0] OP_BRN  = 4'hC;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  // One-hot-ish classification of the opcode; mem covers both LD and ST.
  typedef struct packed {
    logic alu;
    logic mem;
    logic ld;
    logic jmp;
    logic brz;
    logic brn;
    logic halt;
    logic illegal;
  } instr_class_t;

  // Opcode field of an instruction word.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-OPC_W];
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction/data memory port of the sequencer. The sequencer is the
// master: it raises MEM_REQ and holds it until the memory answers MEM_ACK.
interface instr_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic               MEM_REQ;
  logic               MEM_WE;
  logic               MEM_SEL_PC;
  logic               MEM_ACK;
  logic [INSTR_W-1:0] MEM_RDATA;

  modport master (
    output MEM_REQ,
    output MEM_WE,
    output MEM_SEL_PC,
    input  MEM_ACK,
    input  MEM_RDATA
  );

  modport slave (
    input  MEM_REQ,
    input  MEM_WE,
    input  MEM_SEL_PC,
    output MEM_ACK,
    output MEM_RDATA
  );

endinterface

// File: rtl/instr_sequencer_decoder.sv
// Combinational opcode classifier. Opcodes 1..7 are ALU operations,
// 0xD/0xE are reserved and flagged illegal (they still run as a NOP).
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output instr_class_t     cls
);

  // Map the 4-bit opcode onto its instruction class.
  always_comb begin
    cls         = '0;
    cls.alu     = (opcode != OP_NOP) && (opcode < OP_LD);
    cls.ld      = (opcode == OP_LD);
    cls.mem     = (opcode == OP_LD) || (opcode == OP_ST);
    cls.jmp     = (opcode == OP_JMP);
    cls.brz     = (opcode == OP_BRZ);
    cls.brn     = (opcode == OP_BRN);
    cls.halt    = (opcode == OP_HALT);
    cls.illegal = (opcode == 4'hD) || (opcode == 4'hE);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 4-bit CPU core.
// Owns the FSM, instruction register, request timeout and sticky status.
// Every completed non-HALT instruction produces exactly one PC_EN pulse;
// LD/ST complete their memory phase and then reuse EXEC for that pulse.
module instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  instr_sequencer_if.master    bus,
  input  logic                 Z_FLAG,
  input  logic                 N_FLAG,
  output logic [INSTR_W-1:0]   IR,
  output logic                 PC_EN,
  output logic                 PL,
  output logic                 JB,
  output logic                 BC,
  output logic [REG_W-1:0]     LAddress,
  output logic [REG_W-1:0]     RAddress,
  output logic [ALU_W-1:0]     ALU_OP,
  output logic                 RF_WE,
  output logic                 RF_SRC,
  output logic                 HALTED,
  output logic                 ILLEGAL,
  output logic                 BUS_ERR
);

  logic [2:0]   state;
  logic [2:0]   state_nx;
  logic         live;
  logic [7:0]   wait_cnt;
  logic         req;
  logic         ack;
  logic         tmo_hit;
  instr_class_t cls;

  instr_decoder u_dec (
    .opcode (opcode_of(IR)),
    .cls    (cls)
  );

  // FETCH only requests once a clock edge has passed since reset release,
  // so the request and PC-select stay low throughout reset.
  assign req     = ((state == S_FETCH) && live) || (state == S_MEM);
  assign ack     = req && bus.MEM_ACK;
  assign tmo_hit = req && !bus.MEM_ACK && (wait_cnt == 8'(TIMEOUT - 1));

  assign LAddress = IR[3:2];
  assign RAddress = IR[1:0];
  assign ALU_OP   = IR[6:4];
  assign HALTED   = (state == S_HALT);

  // Next-state selection; an ack in the expiry cycle wins over the timeout.
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: begin
        if (ack)          state_nx = S_DECODE;
        else if (tmo_hit) state_nx = S_HALT;
      end
      S_DECODE: begin
        if (cls.halt)     state_nx = S_HALT;
        else if (cls.mem) state_nx = S_MEM;
        else              state_nx = S_EXEC;
      end
      S_EXEC:   state_nx = S_FETCH;
      S_MEM: begin
        if (ack)          state_nx = S_EXEC;
        else if (tmo_hit) state_nx = S_HALT;
      end
      S_HALT: begin
        if (START)        state_nx = S_FETCH;
      end
      default:  state_nx = S_FETCH;
    endcase
  end

  // State register plus the post-reset request enable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_FETCH;
      live  <= 1'b0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
    end
  end

  // Instruction register loads on the fetch acknowledge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                        IR <= '0;
    else if ((state == S_FETCH) && ack) IR <= bus.MEM_RDATA;
  end

  // Wait counter: runs while a request is unanswered, otherwise held at 0,
  // so it is always zero on entry to FETCH or MEM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                 wait_cnt <= '0;
    else if (req && !bus.MEM_ACK) wait_cnt <= wait_cnt + 8'd1;
    else                        wait_cnt <= '0;
  end

  // Sticky status flags, cleared only by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ILLEGAL <= 1'b0;
      BUS_ERR <= 1'b0;
    end else begin
      if ((state == S_DECODE) && cls.illegal) ILLEGAL <= 1'b1;
      if (tmo_hit)                            BUS_ERR <= 1'b1;
    end
  end

  // Strobes decode from state, IR class and the flags seen in EXEC;
  // MEM_ACK only qualifies the LD register write.
  always_comb begin
    bus.MEM_REQ    = req;
    bus.MEM_SEL_PC = (state == S_FETCH) && live;
    bus.MEM_WE     = 1'b0;
    PC_EN          = 1'b0;
    PL             = 1'b0;
    JB             = 1'b0;
    BC             = 1'b0;
    RF_WE          = 1'b0;
    RF_SRC         = 1'b0;
    case (state)
      S_EXEC: begin
        PC_EN = 1'b1;
        RF_WE = cls.alu;
        if (cls.jmp) begin
          PL = 1'b1;
          JB = 1'b1;
        end else if ((cls.brz && Z_FLAG) || (cls.brn && N_FLAG)) begin
          PL = 1'b1;
          BC = cls.brn;
        end
      end
      S_MEM: begin
        bus.MEM_WE = !cls.ld;
        RF_SRC     = cls.ld;
        RF_WE      = cls.ld && ack;
      end
      default: ;
    endcase
  end

endmodule
